// File: rtl/calc_pkg.sv
// Shared constants for the calculator game: key codes, operator codes,
// game-state encodings and the answer-checker FSM state type.
package calc_pkg;

  localparam logic [4:0] KEY_ENTER = 5'd14;
  localparam logic [4:0] KEY_CLEAR = 5'd15;

  localparam logic [4:0] OP_ADD = 5'd11;
  localparam logic [4:0] OP_SUB = 5'd12;
  localparam logic [4:0] OP_MUL = 5'd13;

  localparam logic [3:0] ST_GEN    = 4'd2;
  localparam logic [3:0] ST_ANSWER = 4'd3;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StEntry,
    StVerdict
  } chk_state_e;

endpackage

// File: rtl/answer_timer.sv
// Loadable down-counter for the per-question time limit; expired is high
// while the count sits at zero.
module answer_timer #(
  parameter int unsigned Width = 10
) (
  input  logic             tick,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [Width-1:0] load_val,
  output logic             expired
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/answer_checker.sv
// Latches the generator's result, collects keypad digits and scores the answer.
// Define ANSWER_CHECKER_TIMEOUT_EN to compile in the per-question time limit.
module answer_checker
  import calc_pkg::*;
#(
  parameter logic [3:0]  ANSWER_STATE  = ST_ANSWER,
  parameter int unsigned TIMEOUT_TICKS = 1000
) (
  input  logic        tick,
  input  logic        reset,
  input  logic [3:0]  state,
  input  logic        gen_done,
  input  logic [9:0]  result,
  input  logic        key_valid,
  input  logic [4:0]  key_code,
  output logic [14:0] entry_digits,
  output logic [1:0]  entry_count,
  output logic        check_done,
  output logic        correct,
  output logic        timed_out,
  output logic [7:0]  score
);

  chk_state_e  fsm_q, fsm_d;
  logic [9:0]  exp_q, exp_d;
  logic [9:0]  acc_q, acc_d;
  logic [14:0] digits_q, digits_d;
  logic [1:0]  count_q, count_d;
  logic        correct_q, correct_d;
  logic        timed_out_q, timed_out_d;
  logic        check_done_q, check_done_d;
  logic [7:0]  score_q, score_d;

  logic arm_to_entry;
  logic timeout_hit;

  assign arm_to_entry = (fsm_q == StArmed) && (state == ANSWER_STATE);

`ifdef ANSWER_CHECKER_TIMEOUT_EN
  // Load with TIMEOUT_TICKS-1 so expiry is sampled TIMEOUT_TICKS edges after entry.
  localparam int unsigned TimerW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TimerW-1:0] TimerLoad = TimerW'(TIMEOUT_TICKS - 1);

  logic timer_expired;

  answer_timer #(
    .Width (TimerW)
  ) u_timer (
    .tick     (tick),
    .reset    (reset),
    .load     (arm_to_entry),
    .en       (fsm_q == StEntry),
    .load_val (TimerLoad),
    .expired  (timer_expired)
  );

  assign timeout_hit = (fsm_q == StEntry) && timer_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    digits_d    = digits_q;
    count_d     = count_q;
    correct_d   = correct_q;
    timed_out_d = timed_out_q;

    unique case (fsm_q)
      StIdle: begin
        if (gen_done) begin
          exp_d       = result;
          acc_d       = '0;
          digits_d    = '0;
          count_d     = '0;
          correct_d   = 1'b0;
          timed_out_d = 1'b0;
          fsm_d       = StArmed;
        end
      end
      StArmed: begin
        if (gen_done) exp_d = result;
        if (arm_to_entry) fsm_d = StEntry;
      end
      StEntry: begin
        if (state != ANSWER_STATE) begin
          fsm_d = StIdle;
        end else if (timeout_hit) begin
          correct_d   = 1'b0;
          timed_out_d = 1'b1;
          fsm_d       = StVerdict;
        end else if (key_valid) begin
          if (key_code <= 5'd9) begin
            if (count_q != 2'd3) begin
              // acc < 100 here, so the 10-bit product cannot overflow
              acc_d    = acc_q * 10'd10 + {6'd0, key_code[3:0]};
              digits_d = {digits_q[9:0], key_code};
              count_d  = count_q + 2'd1;
            end
          end else if (key_code == KEY_CLEAR) begin
            acc_d    = '0;
            digits_d = '0;
            count_d  = '0;
          end else if ((key_code == KEY_ENTER) && (count_q != 2'd0)) begin
            correct_d = (acc_q == exp_q);
            fsm_d     = StVerdict;
          end
        end
      end
      StVerdict: begin
        fsm_d = StIdle;
      end
      default: fsm_d = StIdle;
    endcase
  end

  always_comb begin
    check_done_d = (fsm_q == StVerdict);
    score_d      = score_q;
    if ((fsm_q == StVerdict) && correct_q && (score_q != 8'hFF)) begin
      score_d = score_q + 8'd1;
    end
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      fsm_q        <= StIdle;
      exp_q        <= '0;
      acc_q        <= '0;
      digits_q     <= '0;
      count_q      <= '0;
      correct_q    <= 1'b0;
      timed_out_q  <= 1'b0;
      check_done_q <= 1'b0;
      score_q      <= '0;
    end else begin
      fsm_q        <= fsm_d;
      exp_q        <= exp_d;
      acc_q        <= acc_d;
      digits_q     <= digits_d;
      count_q      <= count_d;
      correct_q    <= correct_d;
      timed_out_q  <= timed_out_d;
      check_done_q <= check_done_d;
      score_q      <= score_d;
    end
  end

  assign entry_digits = digits_q;
  assign entry_count  = count_q;
  assign check_done   = check_done_q;
  assign correct      = correct_q;
  assign timed_out    = timed_out_q;
  assign score        = score_q;

endmodule
